// File: rtl/wb_arbiter2_if.sv
// rtl/wb_arbiter2_if.sv - Wishbone bus bundle between two masters, the arbiter and the shared bus
//
// Purpose: groups the master-0, master-1 and shared-bus Wishbone signals so the
// arbiter and its environment connect through one port.
// Modports:
//   slave  - arbiter view: takes m0_/m1_ requests and s_ terminations,
//            drives m0_/m1_ terminations and the s_ request side.
//   master - environment view: the mirror image of slave.

interface wb_arbiter2_if;
  logic        m0_CYC, m0_STB, m0_WE;
  logic [31:0] m0_ADR, m0_DAT_O;
  logic [2:0]  m0_CTI_O;
  logic        m0_ACK, m0_ERR, m0_RTY;
  logic [31:0] m0_DAT_I;

  logic        m1_CYC, m1_STB, m1_WE;
  logic [31:0] m1_ADR, m1_DAT_O;
  logic [2:0]  m1_CTI_O;
  logic        m1_ACK, m1_ERR, m1_RTY;
  logic [31:0] m1_DAT_I;

  logic        s_CYC, s_STB, s_WE;
  logic [31:0] s_ADR, s_DAT_O;
  logic [2:0]  s_CTI_O;
  logic        s_ACK, s_ERR, s_RTY;
  logic [31:0] s_DAT_I;

  modport slave (
    input  m0_CYC, m0_STB, m0_WE, m0_ADR, m0_DAT_O, m0_CTI_O,
    output m0_ACK, m0_ERR, m0_RTY, m0_DAT_I,
    input  m1_CYC, m1_STB, m1_WE, m1_ADR, m1_DAT_O, m1_CTI_O,
    output m1_ACK, m1_ERR, m1_RTY, m1_DAT_I,
    output s_CYC, s_STB, s_WE, s_ADR, s_DAT_O, s_CTI_O,
    input  s_ACK, s_ERR, s_RTY, s_DAT_I
  );

  modport master (
    output m0_CYC, m0_STB, m0_WE, m0_ADR, m0_DAT_O, m0_CTI_O,
    input  m0_ACK, m0_ERR, m0_RTY, m0_DAT_I,
    output m1_CYC, m1_STB, m1_WE, m1_ADR, m1_DAT_O, m1_CTI_O,
    input  m1_ACK, m1_ERR, m1_RTY, m1_DAT_I,
    input  s_CYC, s_STB, s_WE, s_ADR, s_DAT_O, s_CTI_O,
    output s_ACK, s_ERR, s_RTY, s_DAT_I
  );
endinterface

// File: rtl/wb_arbiter2.sv
// rtl/wb_arbiter2.sv - two-master Wishbone arbiter with round-robin grant and bus watchdog
//
// Purpose: grants the shared bus to master 0 or master 1 for a whole CYC
// cycle, alternating on ties, and answers an unanswered strobe with ERR after
// TIMEOUT cycles (TIMEOUT = 0 disables the watchdog).
// Ports:
//   clk        system clock
//   rst        asynchronous active-low reset
//   bus        Wishbone bundle (slave modport: arbiter side)
//   gnt        one-hot owner, 01 = m0, 10 = m1, 00 = idle
//   timeout_o  one-cycle pulse when the watchdog fires

module wb_arbiter2 #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic         clk,
  input  logic         rst,
  wb_arbiter2_if.slave bus,
  output logic [1:0]   gnt,
  output logic         timeout_o
);

  typedef enum logic [1:0] {IDLE = 2'd0, GNT0 = 2'd1, GNT1 = 2'd2} state_e;

  localparam logic [15:0] WD_LAST = (TIMEOUT == 0) ? 16'd0 : 16'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic        last_q, last_d;
  logic [15:0] wd_q, wd_d;
  logic        fire_q, fire_d;

  logic own0, own1, own_stb, term, stall, wd_err;

  assign own0    = (state_q == GNT0);
  assign own1    = (state_q == GNT1);
  assign own_stb = (own0 & bus.m0_STB) | (own1 & bus.m1_STB);
  assign term    = bus.s_ACK | bus.s_ERR | bus.s_RTY;
  // A real slave termination in the fire cycle wins over the watchdog ERR.
  assign wd_err  = fire_q & ~term;
  // The fire cycle masks STB, so it never counts as a stalled cycle.
  assign stall   = own_stb & ~fire_q & ~term;

  assign gnt       = {own1, own0};
  assign timeout_o = wd_err;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      wd_q    <= '0;
      fire_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      wd_q    <= wd_d;
      fire_q  <= fire_d;
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    wd_d    = '0;
    fire_d  = 1'b0;
    case (state_q)
      IDLE: begin
        // On a tie the master that did not own the bus last wins.
        if (bus.m0_CYC && (!bus.m1_CYC || last_q)) begin
          state_d = GNT0;
          last_d  = 1'b0;
        end else if (bus.m1_CYC) begin
          state_d = GNT1;
          last_d  = 1'b1;
        end
      end
      GNT0:    if (!bus.m0_CYC) state_d = IDLE;
      GNT1:    if (!bus.m1_CYC) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Counting only while the owner keeps the bus; wd is cleared at the fire
    // point so it never exceeds WD_LAST.
    if ((TIMEOUT != 0) && stall && (state_d == state_q)) begin
      if (wd_q == WD_LAST) fire_d = 1'b1;
      else                 wd_d   = wd_q + 16'd1;
    end
  end

  always_comb begin
    bus.s_CYC    = 1'b0;
    bus.s_STB    = 1'b0;
    bus.s_WE     = 1'b0;
    bus.s_ADR    = '0;
    bus.s_DAT_O  = '0;
    bus.s_CTI_O  = '0;
    bus.m0_ACK   = 1'b0;
    bus.m0_ERR   = 1'b0;
    bus.m0_RTY   = 1'b0;
    bus.m0_DAT_I = '0;
    bus.m1_ACK   = 1'b0;
    bus.m1_ERR   = 1'b0;
    bus.m1_RTY   = 1'b0;
    bus.m1_DAT_I = '0;
    if (own0) begin
      bus.s_CYC    = bus.m0_CYC;
      bus.s_STB    = bus.m0_STB & ~fire_q;
      bus.s_WE     = bus.m0_WE;
      bus.s_ADR    = bus.m0_ADR;
      bus.s_DAT_O  = bus.m0_DAT_O;
      bus.s_CTI_O  = bus.m0_CTI_O;
      bus.m0_ACK   = bus.s_ACK;
      bus.m0_ERR   = bus.s_ERR | wd_err;
      bus.m0_RTY   = bus.s_RTY;
      bus.m0_DAT_I = bus.s_DAT_I;
    end else if (own1) begin
      bus.s_CYC    = bus.m1_CYC;
      bus.s_STB    = bus.m1_STB & ~fire_q;
      bus.s_WE     = bus.m1_WE;
      bus.s_ADR    = bus.m1_ADR;
      bus.s_DAT_O  = bus.m1_DAT_O;
      bus.s_CTI_O  = bus.m1_CTI_O;
      bus.m1_ACK   = bus.s_ACK;
      bus.m1_ERR   = bus.s_ERR | wd_err;
      bus.m1_RTY   = bus.s_RTY;
      bus.m1_DAT_I = bus.s_DAT_I;
    end
  end

endmodule

// File: tb/tb_wb_arbiter2.sv
// tb/tb_wb_arbiter2.sv - self-checking bench for wb_arbiter2

module tb_wb_arbiter2;
  localparam logic [31:0] ADR0  = 32'h0000_0010;
  localparam logic [31:0] ADR1  = 32'h0000_2000;
  localparam logic [31:0] RDATA = 32'hDEAD_BEEF;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  wb_arbiter2_if bus_a ();
  wb_arbiter2_if bus_b ();
  logic [1:0] gnt_a, gnt_b;
  logic       to_a, to_b;

  wb_arbiter2 #(.TIMEOUT(8)) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a), .gnt(gnt_a), .timeout_o(to_a)
  );
  wb_arbiter2 #(.TIMEOUT(0)) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b), .gnt(gnt_b), .timeout_o(to_b)
  );

  assign bus_b.m0_CYC   = bus_a.m0_CYC;
  assign bus_b.m0_STB   = bus_a.m0_STB;
  assign bus_b.m0_WE    = bus_a.m0_WE;
  assign bus_b.m0_ADR   = bus_a.m0_ADR;
  assign bus_b.m0_DAT_O = bus_a.m0_DAT_O;
  assign bus_b.m0_CTI_O = bus_a.m0_CTI_O;
  assign bus_b.m1_CYC   = bus_a.m1_CYC;
  assign bus_b.m1_STB   = bus_a.m1_STB;
  assign bus_b.m1_WE    = bus_a.m1_WE;
  assign bus_b.m1_ADR   = bus_a.m1_ADR;
  assign bus_b.m1_DAT_O = bus_a.m1_DAT_O;
  assign bus_b.m1_CTI_O = bus_a.m1_CTI_O;
  assign bus_b.s_ACK    = bus_a.s_ACK;
  assign bus_b.s_ERR    = bus_a.s_ERR;
  assign bus_b.s_RTY    = bus_a.s_RTY;
  assign bus_b.s_DAT_I  = bus_a.s_DAT_I;

  typedef struct {
    logic       rstn, c0, s0, c1, s1, ack;
    logic [1:0] gnt;
    logic       sc, sstb, a0, a1;
  } vec_t;

  vec_t tbl[$];
  vec_t v;
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic rn, c0, s0, c1, s1, ak,
                              input logic [1:0] g, input logic sc, ss, a0, a1);
    vec_t r;
    r.rstn = rn; r.c0 = c0; r.s0 = s0; r.c1 = c1; r.s1 = s1; r.ack = ak;
    r.gnt = g; r.sc = sc; r.sstb = ss; r.a0 = a0; r.a1 = a1;
    return r;
  endfunction

  task automatic drive(input logic c0, s0, c1, s1, ak);
    bus_a.m0_CYC = c0; bus_a.m0_STB = s0;
    bus_a.m1_CYC = c1; bus_a.m1_STB = s1;
    bus_a.s_ACK  = ak;
  endtask

  int n_err_a, n_to_a, n_err_b;
  logic [31:0] e_adr, e_d0, e_d1;
  logic        e_we;

  initial begin
    bus_a.m0_WE = 1'b0; bus_a.m0_ADR = ADR0; bus_a.m0_DAT_O = 32'h1111_0000; bus_a.m0_CTI_O = 3'b000;
    bus_a.m1_WE = 1'b1; bus_a.m1_ADR = ADR1; bus_a.m1_DAT_O = 32'h2222_0000; bus_a.m1_CTI_O = 3'b111;
    bus_a.s_ERR = 1'b0; bus_a.s_RTY = 1'b0; bus_a.s_DAT_I = RDATA;
    drive(0, 0, 0, 0, 0);

    // Reset, then m0 single read.
    tbl.push_back(mk(1, 0,0,0,0, 0, 2'b00, 0,0,0,0));
    tbl.push_back(mk(1, 1,1,0,0, 0, 2'b00, 0,0,0,0));
    tbl.push_back(mk(1, 1,1,0,0, 1, 2'b01, 1,1,1,0));
    tbl.push_back(mk(1, 0,0,0,0, 0, 2'b01, 0,0,0,0));
    tbl.push_back(mk(1, 0,0,0,0, 0, 2'b00, 0,0,0,0));
    // Re-reset so the tie sequence starts from last = m1.
    tbl.push_back(mk(0, 0,0,0,0, 0, 2'b00, 0,0,0,0));
    tbl.push_back(mk(1, 0,0,0,0, 0, 2'b00, 0,0,0,0));
    // Four ties: expected owners m0, m1, m0, m1 with an IDLE cycle between.
    for (int t = 0; t < 4; t++) begin
      tbl.push_back(mk(1, 1,1,1,1, 0, 2'b00, 0,0,0,0));
      if (t % 2 == 0) begin
        tbl.push_back(mk(1, 1,1,1,1, 1, 2'b01, 1,1,1,0));
        tbl.push_back(mk(1, 0,0,1,1, 0, 2'b01, 0,0,0,0));
      end else begin
        tbl.push_back(mk(1, 1,1,1,1, 1, 2'b10, 1,1,0,1));
        tbl.push_back(mk(1, 1,1,0,0, 0, 2'b10, 0,0,0,0));
      end
    end
    // Grant hold: m0 runs 3 beats while m1 waits.
    tbl.push_back(mk(1, 1,1,0,0, 0, 2'b00, 0,0,0,0));
    tbl.push_back(mk(1, 1,1,1,1, 1, 2'b01, 1,1,1,0));
    tbl.push_back(mk(1, 1,1,1,1, 0, 2'b01, 1,1,0,0));
    tbl.push_back(mk(1, 1,1,1,1, 1, 2'b01, 1,1,1,0));
    tbl.push_back(mk(1, 1,1,1,1, 1, 2'b01, 1,1,1,0));
    tbl.push_back(mk(1, 0,0,1,1, 0, 2'b01, 0,0,0,0));
    tbl.push_back(mk(1, 0,0,1,1, 0, 2'b00, 0,0,0,0));
    tbl.push_back(mk(1, 0,0,1,1, 1, 2'b10, 1,1,0,1));
    tbl.push_back(mk(1, 0,0,0,0, 0, 2'b10, 0,0,0,0));
    tbl.push_back(mk(1, 0,0,0,0, 0, 2'b00, 0,0,0,0));

    repeat (3) @(negedge clk);

    for (int i = 0; i < tbl.size(); i++) begin
      v = tbl[i];
      @(negedge clk);
      rst = v.rstn;
      drive(v.c0, v.s0, v.c1, v.s1, v.ack);
      #1;
      check($sformatf("vec%0d ctl", i),
            {bus_a.s_CYC, bus_a.s_STB, gnt_a, bus_a.m0_ACK, bus_a.m1_ACK,
             bus_a.m0_ERR, bus_a.m1_ERR, to_a},
            {v.sc, v.sstb, v.gnt, v.a0, v.a1, 3'b000});
      e_adr = (v.gnt == 2'b01) ? ADR0  : (v.gnt == 2'b10) ? ADR1 : 32'h0;
      e_d0  = (v.gnt == 2'b01) ? RDATA : 32'h0;
      e_d1  = (v.gnt == 2'b10) ? RDATA : 32'h0;
      e_we  = (v.gnt == 2'b10);
      check($sformatf("vec%0d data", i),
            {bus_a.s_ADR, bus_a.m0_DAT_I, bus_a.m1_DAT_I, 31'b0, bus_a.s_WE},
            {e_adr, e_d0, e_d1, 31'b0, e_we});
    end

    // Watchdog: m1 strobes ADR1 with no slave answer.
    @(negedge clk);
    drive(0, 0, 1, 1, 0);
    n_err_a = 0; n_to_a = 0; n_err_b = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      #1;
      if (bus_a.m1_ERR) n_err_a++;
      if (to_a)         n_to_a++;
      if (bus_b.m1_ERR || to_b) n_err_b++;
      if (i == 7) check("wd before fire", {bus_a.m1_ERR, to_a, bus_a.s_STB, gnt_a}, {3'b001, 2'b10});
      if (i == 8) check("wd fire",        {bus_a.m1_ERR, to_a, bus_a.s_STB, gnt_a}, {3'b110, 2'b10});
      if (i == 9) check("wd after fire",  {bus_a.m1_ERR, to_a, bus_a.s_STB, gnt_a}, {3'b001, 2'b10});
    end
    check("wd err count t8", n_err_a, 111);
    check("wd pulse count t8", n_to_a, 111);
    check("wd err count t0", n_err_b, 0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0);

    // Termination race: ACK lands in the cycle the watchdog would fire.
    @(negedge clk);
    drive(1, 1, 0, 0, 0);
    n_err_a = 0;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      if (i == 8) bus_a.s_ACK = 1'b1;
      #1;
      if (i < 8 && (bus_a.m0_ERR || to_a)) n_err_a++;
      if (i == 8) check("race ack wins", {bus_a.m0_ACK, bus_a.m0_ERR, to_a, gnt_a}, {3'b100, 2'b01});
    end
    check("race no early err", n_err_a, 0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0);

    // Async reset during m0's second beat.
    @(negedge clk);
    drive(1, 1, 0, 0, 0);
    @(negedge clk);
    bus_a.s_ACK = 1'b1;
    @(negedge clk);
    #1;
    check("burst beat2 active", {bus_a.s_CYC, gnt_a}, {1'b1, 2'b01});
    #1;
    rst = 1'b0;
    #1;
    check("async reset drop", {bus_a.s_CYC, bus_a.s_STB, gnt_a, bus_a.m0_ACK}, 5'b0);
    @(negedge clk);
    rst = 1'b1;
    drive(0, 0, 0, 0, 0);
    @(negedge clk);
    drive(1, 1, 1, 1, 0);
    @(negedge clk);
    #1;
    check("tie after reset", {gnt_a, gnt_b}, {2'b01, 2'b01});
    @(negedge clk);
    drive(0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wb_arbiter2.md
# wb_arbiter2

Two-master Wishbone classic/registered-feedback bus arbiter with a bus-timeout watchdog. It sits between the CPU core (master 0) and a second bus master such as a DMA or debug port (master 1) on one side, and the SoC address decoder on the other. It grants the single shared bus with round-robin fairness and holds the grant for a whole CYC cycle. It terminates any access that no slave answers within a bounded number of cycles by returning ERR to the owning master.

## Interface
Parameters:
- TIMEOUT, 255: cycles of unanswered STB before the arbiter returns ERR. 0 disables the watchdog. Range 0..65535.

Ports (prefix m0_/m1_ = master side, s_ = shared bus toward the decoder):
- clk  in  1  system clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- m0_CYC, m0_STB, m0_WE  in  1 each  master 0 cycle, strobe, write-enable.
- m0_ADR, m0_DAT_O  in  32 each  master 0 address and write data.
- m0_CTI_O  in  3  master 0 cycle type.
- m0_ACK, m0_ERR, m0_RTY  out  1 each  terminations to master 0.
- m0_DAT_I  out  32  read data to master 0.
- m1_*: identical set for master 1.
- s_CYC, s_STB, s_WE  out  1 each  shared bus controls.
- s_ADR, s_DAT_O  out  32 each  shared bus address and write data.
- s_CTI_O  out  3  shared bus cycle type.
- s_ACK, s_ERR, s_RTY  in  1 each  terminations from the decoder.
- s_DAT_I  in  32  read data from the decoder.
- gnt  out  2  one-hot current owner: 01 = m0, 10 = m1, 00 = idle.
- timeout_o  out  1  one-cycle pulse when the watchdog fires.

## Operation
- FSM states: IDLE, GNT0, GNT1. Also a last-owner flag `last` and a 16-bit watchdog counter `wd`.
- Arbitration takes place in IDLE:
  - Only m0_CYC high: next state is GNT0.
  - Only m1_CYC high: next state is GNT1.
  - Both high: grant the master that was not `last`.
  - Neither high: stay in IDLE.
- On entering GNTx, `last` is set to x.
- In GNTx, stay while mx_CYC = 1. When mx_CYC = 0, go to IDLE. One IDLE cycle always separates two grants.
- Forwarding while in GNTx:
  - s_CYC, s_STB, s_WE, s_ADR, s_DAT_O and s_CTI_O are driven combinationally from master x.
  - mx_ACK, mx_ERR, mx_RTY and mx_DAT_I are driven from the s_ side.
  - The non-owner sees ACK = ERR = RTY = 0 and DAT_I = 0.
- In IDLE: every s_ output is 0, and every master's ACK/ERR/RTY is 0.
- The grant never changes mid-cycle, so a master holding CYC across several STB beats (burst or read-modify-write) keeps the bus.
- Watchdog:
  - In GNTx with s_STB = 1 and s_ACK, s_ERR and s_RTY all 0, `wd` increments.
  - Any termination, s_STB = 0, or leaving GNTx clears `wd` to 0.
  - When `wd` = TIMEOUT−1 and the condition still holds, the next cycle:
    - asserts mx_ERR = 1 for exactly one cycle;
    - masks s_STB to 0 for that cycle;
    - pulses timeout_o;
    - clears `wd`.
  - A genuine slave termination in the same cycle takes precedence, and the watchdog does not fire.
  - Arithmetic is unsigned 16-bit. `wd` saturates and never wraps, because it is cleared at the fire point.
- TIMEOUT = 0: `wd` is held at 0 and the watchdog never fires.

## Timing
- Reset (rst = 0, asynchronous): state IDLE, `last` = 1 (so m0 wins the first tie), `wd` = 0, gnt = 00, timeout_o = 0. All s_ outputs and all master-side outputs are 0.
- Reset asserted mid-transfer drops s_CYC/s_STB immediately, without waiting for a clock. An in-flight slave ACK is discarded.
- Grant latency: mx_CYC rising at edge N (seen in IDLE) gives gnt and s_CYC high after edge N+1. Minimum access is 2 cycles plus slave latency.
- Terminations pass through combinationally: zero added latency from s_ACK to mx_ACK.
- Watchdog fire: s_STB is first asserted in cycle k with no termination. mx_ERR and timeout_o are high in cycle k+TIMEOUT.
- Simultaneous events:
  - Both CYC rising in the same IDLE cycle resolves by `last`.
  - Owner dropping CYC while the other master requests gives IDLE for one cycle, then the other master is granted.

## Test plan
- Reset and m0 request: after rst release, m0 issues a read of ADR 0x0000_0010 and the slave returns ACK with 0xDEADBEEF. Required: gnt = 01 one cycle after m0_CYC, m0_DAT_I = 0xDEADBEEF with m0_ACK, m1_ACK stays 0.
- Simultaneous tie: both CYC rise together, repeated 4 times, each with single-beat transfers. Required grant order m0, m1, m0, m1, with one IDLE cycle between grants.
- Grant hold: m0 holds CYC for 3 STB beats while m1 requests. Required: m1 is not granted until 1 cycle after m0_CYC falls, and s_ADR never shows m1_ADR during m0's cycle.
- Watchdog: TIMEOUT = 8, m1 accesses ADR 0x0000_2000 and no slave answers. Required: m1_ERR and timeout_o are high for exactly one cycle, 8 cycles after STB. With TIMEOUT = 0 and the same stimulus, no ERR appears after 1000 cycles.
- Termination race: the slave ACK arrives in the same cycle the watchdog would fire. Required: ACK is delivered, ERR = 0, timeout_o = 0.
- Async reset mid-burst: rst asserted between clock edges during m0's second beat. Required: s_CYC = 0 and gnt = 00 before the next edge, and after release a tie goes to m0.
